// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel synchroniser, shared sample-tick prescaler, STABLE_COUNT-tick qualification.
// Latency SYNC_STAGES + up to STABLE_COUNT*TICK_DIV + 1 clocks; no backpressure, strobes last exactly one clock.
module debounce_multi #(
  parameter int                  CHANNELS     = 4,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  TICK_DIV     = 6000,
  parameter int                  STABLE_COUNT = 4,
  parameter logic [CHANNELS-1:0] INVERT       = '0,
  parameter logic [CHANNELS-1:0] INIT_LEVEL   = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed,
  output logic                tick
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              CW      = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_COUNT - 1);

  logic [PW-1:0]       pre;
  logic [CHANNELS-1:0] sync [SYNC_STAGES];
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] samp;
  logic [CHANNELS-1:0] state_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  assign samp = sync[SYNC_STAGES-1] ^ INVERT;

  // Qualification only advances on the registered tick; any agreeing sample restarts it.
  always_comb begin
    state_nxt = state;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (samp[i] != state[i]) begin
          if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = samp[i];
            cnt_nxt[i]   = '0;
            rise_nxt[i]  = samp[i];
            fall_nxt[i]  = ~samp[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end else begin
          cnt_nxt[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre  <= '0;
      tick <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= INIT_LEVEL ^ INVERT;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      state   <= INIT_LEVEL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      pre  <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
      tick <= (pre == PRE_MAX);
      sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
      state   <= state_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios then random bouncing, two builds checked every cycle.
module tb_debounce_multi;

  localparam int              TDV [2] = '{4, 1};
  localparam int              SCV [2] = '{3, 1};
  localparam logic [3:0]      INV [2] = '{4'h0, 4'h1};
  localparam logic [3:0]      INIT    = 4'h0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] in;
  logic [3:0] st0, ri0, fa0, st1, ri1, fa1;
  logic       ch0, tk0, ch1, tk1;

  always #5 clock = ~clock;

  debounce_multi #(.CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_COUNT(3),
                   .INVERT(4'h0), .INIT_LEVEL(4'h0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in(in), .state(st0), .rise(ri0),
    .fall(fa0), .changed(ch0), .tick(tk0));

  debounce_multi #(.CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_COUNT(1),
                   .INVERT(4'h1), .INIT_LEVEL(4'h0)) dut1 (
    .clock(clock), .reset_n(reset_n), .in(in), .state(st1), .rise(ri1),
    .fall(fa1), .changed(ch1), .tick(tk1));

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: input history, tick schedule, and a window of tick samples since each channel's last flip.
  logic [3:0] m_state [2];
  logic [3:0] m_rise  [2];
  logic [3:0] m_fall  [2];
  logic       m_tick  [2];
  int         r       [2];
  int         ntick   [2];
  int         lastflip [2][4];
  logic [3:0] tsamp   [2][8];
  logic [3:0] h1_in, h2_in;
  logic       h1_rst = 1'b1, h2_rst = 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic       pt;
    logic       ok;
    logic [3:0] s;
    for (int m = 0; m < 2; m++) begin
      m_rise[m] = 4'h0;
      m_fall[m] = 4'h0;
      if (!reset_n) begin
        m_state[m] = INIT;
        m_tick[m]  = 1'b0;
        r[m]       = 0;
        ntick[m]   = 0;
        for (int c = 0; c < 4; c++) lastflip[m][c] = 0;
      end else begin
        pt        = m_tick[m];
        r[m]      = r[m] + 1;
        m_tick[m] = (r[m] % TDV[m] == 0);
        if (pt) begin
          s = h2_rst ? INIT : (h2_in ^ INV[m]);
          tsamp[m][ntick[m] % 8] = s;
          ntick[m] = ntick[m] + 1;
          for (int c = 0; c < 4; c++) begin
            if (ntick[m] - lastflip[m][c] >= SCV[m]) begin
              ok = 1'b1;
              for (int j = 1; j <= SCV[m]; j++)
                if (tsamp[m][(ntick[m] - j) % 8][c] == m_state[m][c]) ok = 1'b0;
              if (ok) begin
                m_state[m][c]  = s[c];
                m_rise[m][c]   = s[c];
                m_fall[m][c]   = ~s[c];
                lastflip[m][c] = ntick[m];
              end
            end
          end
        end
      end
    end
    h2_in  = h1_in;
    h2_rst = h1_rst;
    h1_in  = in;
    h1_rst = !reset_n;
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    chk("d0.state",   {4'h0, st0}, {4'h0, m_state[0]});
    chk("d0.rise",    {4'h0, ri0}, {4'h0, m_rise[0]});
    chk("d0.fall",    {4'h0, fa0}, {4'h0, m_fall[0]});
    chk("d0.changed", {7'h0, ch0}, {7'h0, |(m_rise[0] | m_fall[0])});
    chk("d0.tick",    {7'h0, tk0}, {7'h0, m_tick[0]});
    chk("d1.state",   {4'h0, st1}, {4'h0, m_state[1]});
    chk("d1.rise",    {4'h0, ri1}, {4'h0, m_rise[1]});
    chk("d1.fall",    {4'h0, fa1}, {4'h0, m_fall[1]});
    chk("d1.changed", {7'h0, ch1}, {7'h0, |(m_rise[1] | m_fall[1])});
    chk("d1.tick",    {7'h0, tk1}, {7'h0, m_tick[1]});
  endtask

  initial begin
    int n;
    int rate;
    reset_n = 1'b0;
    in      = 4'hF;

    // 1: reset values, then tick cadence after release
    repeat (3) step();
    chk("t1.rst_state", {4'h0, st0}, 8'h00);
    chk("t1.rst_tick",  {7'h0, tk0}, 8'h00);
    reset_n = 1'b1;
    in      = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t1.tick_cadence", {7'h0, tk0}, {7'h0, (i % 4 == 0)});
    end
    chk("x.invert_state", {4'h0, st1}, 8'h01);
    repeat (6) step();

    // 2: clean rising step on channel 0
    in[0] = 1'b1;
    n = 0;
    while (st0[0] !== 1'b1 && n < 40) begin step(); n++; end
    chk("t2.latency_ok", 8'(n <= 15), 8'h01);
    chk("t2.rise",       {4'h0, ri0}, 8'h01);
    chk("t2.changed",    {7'h0, ch0}, 8'h01);
    chk("t2.others",     {4'h0, st0}, 8'h01);
    step();
    chk("t2.rise_once",  {4'h0, ri0}, 8'h00);

    // 3: channel 1 bounces every 5 clocks, never qualifies
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) in[1] = ~in[1];
      step();
    end
    in[1] = 1'b0;
    repeat (20) step();
    chk("t3.state1", {7'h0, st0[1]}, 8'h00);

    // 4: channel 2 rises, then release produces a fall strobe
    in[2] = 1'b1;
    n = 0;
    while (st0[2] !== 1'b1 && n < 40) begin step(); n++; end
    chk("t4.rose", {7'h0, st0[2]}, 8'h01);
    in[2] = 1'b0;
    n = 0;
    while (fa0[2] !== 1'b1 && n < 40) begin step(); n++; end
    chk("t4.fall_latency_ok", 8'(n <= 15), 8'h01);
    chk("t4.fall", {4'h0, fa0}, 8'h04);

    // 5: all channels at once
    in = 4'h0;
    repeat (20) step();
    in = 4'hF;
    n = 0;
    while (ri0 === 4'h0 && n < 40) begin step(); n++; end
    chk("t5.rise_all", {4'h0, ri0}, 8'h0F);

    // 6: reset mid-qualification discards progress
    in = 4'h0;
    repeat (20) step();
    in[3] = 1'b1;
    n = 0;
    while (n < 2) begin
      step();
      if (tk0 === 1'b1) n++;
    end
    reset_n = 1'b0;
    repeat (2) step();
    chk("t6.rst_state3", {7'h0, st0[3]}, 8'h00);
    reset_n = 1'b1;
    n = 0;
    while (ri0[3] !== 1'b1 && n < 40) begin step(); n++; end
    chk("t6.requal_clks", 8'(n), 8'd13);

    // Random bouncing at varying rates with occasional resets
    for (int seg = 0; seg < 12; seg++) begin
      rate = $urandom_range(2, 40);
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, rate - 1) == 0) in[c] = ~in[c];
        reset_n = ($urandom_range(0, 499) != 0);
        step();
      end
    end
    reset_n = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
